// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU/LSB results and broadcasts one per cycle, round-robin.
// Latency 1 cycle on bypass; rdy=0 freezes everything; a full queue drops new results and sets overflow.

// Per-source result queue; simultaneous push/pop is legal when full.
// Latency: head visible the cycle after push; en=0 holds state, clr empties.
// No internal backpressure: the caller must not push into a full queue without popping.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_dat,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (en && !clr && push) mem[tail] <= push_dat;
  end

  assign head_dat = mem[head];
endmodule

// Top-level CDB arbiter.
// Latency: 1 cycle from grant to cdb_* (registered outputs).
// Backpressure: none toward sources; overflow flags any result lost to a full queue.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             clr,
  input  logic             alu_result_ready,
  input  logic [ROB_W-1:0] alu_result_rob_pos,
  input  logic [31:0]      alu_result_val,
  input  logic             lsb_result_ready,
  input  logic [ROB_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]      lsb_result_val,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_pos,
  output logic [31:0]      cdb_val,
  output logic             alu_full,
  output logic             lsb_full,
  output logic             overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ROB_W-1:0] tag;
    logic [31:0]      val;
  } ent_t;

  ent_t alu_in, lsb_in, alu_head, lsb_head, grant_dat;
  logic [CW-1:0] alu_cnt, lsb_cnt;
  logic alu_pres, lsb_pres, alu_cand, lsb_cand;
  logic grant_alu, grant_lsb, alu_pop, lsb_pop, alu_push, lsb_push, drop;
  logic last_alu;  // 1: ALU took the most recent grant

  assign alu_in   = '{tag: alu_result_rob_pos, val: alu_result_val};
  assign lsb_in   = '{tag: lsb_result_rob_pos, val: lsb_result_val};
  assign alu_full = (alu_cnt == CW'(FIFO_DEPTH));
  assign lsb_full = (lsb_cnt == CW'(FIFO_DEPTH));

  always_comb begin
    alu_pres  = rdy && alu_result_ready && (alu_result_rob_pos != '0);
    lsb_pres  = rdy && lsb_result_ready && (lsb_result_rob_pos != '0);
    alu_cand  = (alu_cnt != '0) || alu_pres;
    lsb_cand  = (lsb_cnt != '0) || lsb_pres;
    grant_alu = rdy && alu_cand && (!lsb_cand || !last_alu);
    grant_lsb = rdy && lsb_cand && !grant_alu;
    alu_pop   = grant_alu && (alu_cnt != '0);
    lsb_pop   = grant_lsb && (lsb_cnt != '0);
    // A bypassed input is consumed directly; otherwise it queues if there is (or will be) room.
    alu_push  = alu_pres && !(grant_alu && (alu_cnt == '0)) && (!alu_full || alu_pop);
    lsb_push  = lsb_pres && !(grant_lsb && (lsb_cnt == '0)) && (!lsb_full || lsb_pop);
    drop      = (alu_pres && alu_full && !alu_pop) || (lsb_pres && lsb_full && !lsb_pop);
    grant_dat = '0;
    if (grant_alu)      grant_dat = (alu_cnt != '0) ? alu_head : alu_in;
    else if (grant_lsb) grant_dat = (lsb_cnt != '0) ? lsb_head : lsb_in;
  end

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ent_t))) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .en(rdy), .clr(clr),
    .push(alu_push), .pop(alu_pop), .push_dat(alu_in),
    .head_dat(alu_head), .count(alu_cnt)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ent_t))) u_lsb_fifo (
    .clk(clk), .rst_n(rst_n), .en(rdy), .clr(clr),
    .push(lsb_push), .pop(lsb_pop), .push_dat(lsb_in),
    .head_dat(lsb_head), .count(lsb_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid   <= 1'b0;
      cdb_rob_pos <= '0;
      cdb_val     <= '0;
      overflow    <= 1'b0;
      last_alu    <= 1'b0;
    end else if (clr) begin
      cdb_valid <= 1'b0;
      overflow  <= 1'b0;
      last_alu  <= 1'b0;
    end else if (rdy) begin
      cdb_valid <= grant_alu || grant_lsb;
      if (grant_alu || grant_lsb) begin
        cdb_rob_pos <= grant_dat.tag;
        cdb_val     <= grant_dat.val;
        last_alu    <= grant_alu;
      end
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-traced grant sequences, overflow, flush, freeze and async reset.
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, rdy, clr;
  logic        alu_result_ready, lsb_result_ready;
  logic [4:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        cdb_valid, alu_full, lsb_full, overflow;
  logic [4:0]  cdb_rob_pos;
  logic [31:0] cdb_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(2), .ROB_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
    .alu_result_ready(alu_result_ready), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_result_ready(lsb_result_ready), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .alu_full(alu_full), .lsb_full(lsb_full), .overflow(overflow)
  );

  // Tags are unique within each scenario, so the value is derived from the tag.
  int s37a [7]  = '{10, 11, 12, 0, 0, 0, 0};
  int s37l [7]  = '{1, 2, 3, 0, 0, 0, 0};
  int e37  [7]  = '{10, 1, 11, 2, 12, 3, 0};
  int s38a [10] = '{4, 5, 6, 7, 8, 9, 0, 0, 0, 0};
  int s38l [10] = '{20, 21, 22, 0, 23, 0, 0, 0, 0, 0};
  int e38  [10] = '{4, 20, 5, 21, 6, 22, 7, 23, 8, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] vf(input int t);
    return 32'hA500_0000 | 32'(t);
  endfunction

  task automatic cyc(input int at, input int lt);
    alu_result_ready   = (at != 0);
    alu_result_rob_pos = 5'(at);
    alu_result_val     = vf(at);
    lsb_result_ready   = (lt != 0);
    lsb_result_rob_pos = 5'(lt);
    lsb_result_val     = vf(lt);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int t);
    if (t == 0) begin
      chk({nm, "_valid"}, 64'(cdb_valid), 64'd0);
    end else begin
      chk({nm, "_valid"}, 64'(cdb_valid), 64'd1);
      chk({nm, "_tag"}, 64'(cdb_rob_pos), 64'(t));
      chk({nm, "_val"}, 64'(cdb_val), 64'(vf(t)));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy   = 1'b1;
    clr   = 1'b0;
    alu_result_ready = 1'b0;
    lsb_result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; rdy = 1'b1; clr = 1'b0;
    alu_result_ready = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result_ready = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag", 64'(cdb_rob_pos), 64'd0);
    chk("rst_val", 64'(cdb_val), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_afull", 64'(alu_full), 64'd0);
    chk("rst_lfull", 64'(lsb_full), 64'd0);
    do_reset();

    // Single ALU result, bypass path
    alu_result_ready = 1'b1; alu_result_rob_pos = 5'd3; alu_result_val = 32'h11;
    @(posedge clk); #1;
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_rob_pos), 64'd3);
    chk("single_val", 64'(cdb_val), 64'h11);
    cyc(0, 0);
    chk("single_idle_valid", 64'(cdb_valid), 64'd0);
    chk("single_idle_hold", 64'(cdb_rob_pos), 64'd3);

    // Simultaneous arrival after reset: ALU first, LSB queued one cycle
    do_reset();
    cyc(2, 5);
    expect_out("tie0", 2);
    chk("tie0_lcnt", 64'(dut.lsb_cnt), 64'd1);
    cyc(0, 0);
    expect_out("tie1", 5);
    chk("tie1_lcnt", 64'(dut.lsb_cnt), 64'd0);
    cyc(0, 0);
    expect_out("tie2", 0);

    // Alternation with an LSB burst
    for (int i = 0; i < 7; i++) begin
      cyc(s37a[i], s37l[i]);
      expect_out($sformatf("rr%0d", i), e37[i]);
      if (i == 1) chk("rr_lfull_c1", 64'(lsb_full), 64'd0);
      if (i == 2) chk("rr_lfull_c2", 64'(lsb_full), 64'd1);
    end
    chk("rr_ovf", 64'(overflow), 64'd0);

    // ALU queue fills; tag 9 arrives full with no pop and is dropped
    for (int i = 0; i < 10; i++) begin
      cyc(s38a[i], s38l[i]);
      expect_out($sformatf("ovf%0d", i), e38[i]);
      if (i == 3) chk("ovf_afull", 64'(alu_full), 64'd1);
      if (i == 4) chk("ovf_pre", 64'(overflow), 64'd0);
      if (i == 5) chk("ovf_set", 64'(overflow), 64'd1);
    end
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Flush with entries queued and inputs present
    cyc(10, 11); expect_out("clr_a", 11);
    cyc(12, 13); expect_out("clr_b", 10);
    cyc(14, 15); expect_out("clr_c", 13);
    chk("clr_pre_afull", 64'(alu_full), 64'd1);
    clr = 1'b1;
    cyc(16, 17);
    clr = 1'b0;
    chk("clr_valid", 64'(cdb_valid), 64'd0);
    chk("clr_afull", 64'(alu_full), 64'd0);
    chk("clr_lfull", 64'(lsb_full), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      expect_out($sformatf("clr_idle%0d", i), 0);
    end
    cyc(18, 19); expect_out("clr_tie0", 18);
    cyc(0, 0);   expect_out("clr_tie1", 19);
    cyc(0, 0);   expect_out("clr_tie2", 0);

    // Freeze with rdy=0 while an entry is queued
    cyc(3, 4); expect_out("frz_a", 3);
    cyc(5, 0); expect_out("frz_b", 4);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(6, 7);
      expect_out($sformatf("frz_hold%0d", i), 4);
      chk($sformatf("frz_acnt%0d", i), 64'(dut.alu_cnt), 64'd1);
    end
    rdy = 1'b1;
    cyc(0, 0); expect_out("frz_drain", 5);
    cyc(0, 0); expect_out("frz_empty", 0);

    // Asynchronous reset between edges
    cyc(9, 0); expect_out("arst_pre", 9);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(cdb_valid), 64'd0);
    chk("arst_tag", 64'(cdb_rob_pos), 64'd0);
    chk("arst_val", 64'(cdb_val), 64'd0);
    alu_result_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0);
    expect_out("arst_post", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per source queue (power of two, >=2).
REQ-002 SHALL have parameter ROB_W, default 5, meaning ROB tag width; tag 0 means "no tag".
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  input  1  global run enable; low freezes all state.
REQ-006 SHALL have port clr  input  1  synchronous flush on mispredict.
REQ-007 SHALL have port alu_result_ready  input  1  ALU result valid this cycle.
REQ-008 SHALL have port alu_result_rob_pos  input  ROB_W  ALU result tag.
REQ-009 SHALL have port alu_result_val  input  32  ALU result value.
REQ-010 SHALL have port lsb_result_ready  input  1  LSB load result valid this cycle.
REQ-011 SHALL have port lsb_result_rob_pos  input  ROB_W  LSB result tag.
REQ-012 SHALL have port lsb_result_val  input  32  LSB result value.
REQ-013 SHALL have port cdb_valid  output  1  broadcast valid (registered).
REQ-014 SHALL have port cdb_rob_pos  output  ROB_W  broadcast tag (registered).
REQ-015 SHALL have port cdb_val  output  32  broadcast value (registered).
REQ-016 SHALL have port alu_full  output  1  ALU queue holds FIFO_DEPTH entries.
REQ-017 SHALL have port lsb_full  output  1  LSB queue holds FIFO_DEPTH entries.
REQ-018 SHALL have port overflow  output  1  sticky: a result arrived while its queue was full.

Function
REQ-019 SHALL keep one FIFO per source (ALU, LSB), each with head/tail pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-020 SHALL treat an input as present only when its ready is 1, its tag is nonzero and rdy=1.
REQ-021 SHALL form per-source candidate: FIFO head if count>0, else the present input (bypass), else none.
REQ-022 SHALL grant exactly one candidate per rdy=1 cycle; with both candidates, the source not granted last wins (round-robin); with one candidate, that source wins.
REQ-023 SHALL register the granted tag/value onto cdb_* with cdb_valid=1 on the next edge (latency 1 cycle, bypass case); with no candidate, cdb_valid<=0 and cdb_rob_pos/cdb_val hold.
REQ-024 SHALL update the last-grant flag only on a grant.
REQ-025 SHALL enqueue a present input at the tail unless it was granted via bypass; a granted head is dequeued in the same cycle.
REQ-026 SHALL, when a queue is full and its head is granted the same cycle an input arrives, accept the input (simultaneous pop+push, count unchanged).
REQ-027 SHALL, when a queue is full, not popped, and an input arrives, drop the input and set overflow to 1 until reset or clr.
REQ-028 SHALL wrap pointers modulo FIFO_DEPTH.
REQ-029 SHALL drive alu_full/lsb_full combinationally from registered counts only.
REQ-030 SHALL preserve per-source order; results from one source are broadcast in arrival order.
REQ-031 SHALL, with rdy=0, hold all registers and outputs and ignore inputs.
REQ-032 SHALL, on clr=1 with rdy=1 or rdy=0 (clr wins), empty both queues, set cdb_valid<=0, overflow<=0, last-grant<=LSB; inputs that cycle are discarded.

Reset
REQ-033 SHALL, while rst_n=0, force cdb_valid=0, cdb_rob_pos=0, cdb_val=0, overflow=0, both counts/pointers=0, last-grant=LSB (ALU wins first tie), regardless of clk.
REQ-034 SHALL resume normal operation on the first rising edge after rst_n deasserts; reset mid-burst discards all queued results.

Verification
REQ-035 SHALL pass: ALU tag 3 val 0x11 alone, queues empty -> next cycle cdb_valid=1, tag 3, val 0x11; following cycle cdb_valid=0.
REQ-036 SHALL pass: after reset, ALU tag 2/0xA and LSB tag 5/0xB same cycle -> cycle+1 tag 2, cycle+2 tag 5; lsb queue count 1 then 0.
REQ-037 SHALL pass: LSB tags 1,2,3 on consecutive cycles while ALU present every cycle -> output alternates ALU/LSB, LSB tags in order 1,2,3, lsb_full asserts at count 2, overflow stays 0.
REQ-038 SHALL pass: fill ALU queue (depth 2) with ALU winning nothing (hold rdy... force LSB wins by prior grant pattern), then push third ALU result with no pop -> overflow=1, dropped tag never appears on cdb.
REQ-039 SHALL pass: two entries queued, clr=1 one cycle -> next cycle cdb_valid=0, alu_full=lsb_full=0, overflow=0, queued tags never broadcast.
REQ-040 SHALL pass: rst_n pulled low mid-cycle with cdb_valid=1 -> cdb_valid=0 immediately without clock edge; rdy=0 for 3 cycles with queued entries -> outputs unchanged, no entries lost.
